// File: rtl/mem_pkg.sv
// Shared encodings for the unified memory: funct3 access codes, MMIO map,
// and the load-extension helper used on the registered read path.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [31:0] MMIO_LEDS   = 32'hFFFF_FFFC;
  localparam logic [31:0] MMIO_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] MMIO_MICROS = 32'hFFFF_FFF4;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_MMIO} src_e;

  // funct3[1:0] alone decides width; 3/6/7 collapse onto word width.
  function automatic size_e access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return SZ_B;
      2'd1:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'b0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'b0, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running microsecond and millisecond counters derived from the core clock.
module mmio_timer
  import mem_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12_000_000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] micros,
  output logic [31:0] millis
);

  // Sub-MHz clocks degrade to one micros tick per cycle rather than never ticking.
  localparam int unsigned DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;
  logic [9:0]    sub;
  logic          us_tick;

  assign us_tick = (pre == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pre    <= '0;
      sub    <= '0;
      micros <= '0;
      millis <= '0;
    end else begin
      pre <= us_tick ? '0 : pre + 1'b1;
      if (us_tick) begin
        micros <= micros + 32'd1;
        if (sub == 10'd999) begin
          sub    <= '0;
          millis <= millis + 32'd1;
        end else begin
          sub <= sub + 10'd1;
        end
      end
    end
  end

endmodule

// File: rtl/unified_memory.sv
// Byte-addressable word RAM plus LED/timer MMIO behind one load/store port,
// with a one-cycle registered read and a sticky access fault flag.
module unified_memory
  import mem_pkg::*;
#(
  parameter              INIT_FILE   = "",
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned CLK_HZ      = 12_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  leds,
  output logic        access_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] micros, millis;

  mmio_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .micros (micros),
    .millis (millis)
  );

  size_e       size;
  logic        ram_hit, leds_hit, millis_hit, micros_hit;
  logic        ld_bad, misalign, fault, store_ok;
  logic [3:0]  be, ram_we;
  logic [31:0] wdata, mmio_word;
  logic [AW-1:0] idx;

  assign size       = access_size(funct3);
  assign idx        = address[AW+1:2];
  assign ram_hit    = (address[31:AW+2] == '0);
  assign leds_hit   = (address[31:2] == MMIO_LEDS[31:2]);
  assign millis_hit = (address[31:2] == MMIO_MILLIS[31:2]);
  assign micros_hit = (address[31:2] == MMIO_MICROS[31:2]);

  assign ld_bad   = !mem_write && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
  assign misalign = (size == SZ_H && address[0]) || (size == SZ_W && address[1:0] != 2'b00);
  assign fault    = ld_bad || misalign || !(ram_hit || leds_hit || millis_hit || micros_hit);
  assign store_ok = mem_write && !fault && !reset;

  // Store data is right-aligned, so replicate it across every lane it could land in.
  always_comb begin
    be    = 4'b0000;
    wdata = write_data;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << address[1:0];
        wdata = {4{write_data[7:0]}};
      end
      SZ_H: begin
        be    = address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_data[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign ram_we = (store_ok && ram_hit) ? be : 4'b0000;

  always_comb begin
    mmio_word = 32'd0;
    if (leds_hit)        mmio_word = {24'd0, leds};
    else if (millis_hit) mmio_word = millis;
    else if (micros_hit) mmio_word = micros;
  end

  logic [31:0] ram_q, mmio_q;
  src_e        src_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  // Nonblocking read next to the lane writes gives read-before-write on collisions.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ram[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    ram_q <= ram[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q        <= SRC_NONE;
      off_q        <= 2'b00;
      f3_q         <= F3_W;
      mmio_q       <= 32'd0;
      leds         <= 8'd0;
      access_fault <= 1'b0;
    end else begin
      src_q  <= fault ? SRC_NONE : (ram_hit ? SRC_RAM : SRC_MMIO);
      off_q  <= address[1:0];
      f3_q   <= funct3;
      mmio_q <= mmio_word;
      if (fault) access_fault <= 1'b1;
      if (store_ok && leds_hit && be[0]) leds <= wdata[7:0];
    end
  end

  always_comb begin
    read_data = 32'd0;
    case (src_q)
      SRC_RAM:  read_data = load_extend(ram_q, off_q, f3_q);
      SRC_MMIO: read_data = load_extend(mmio_q, off_q, f3_q);
      default:  read_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_unified_memory.sv
// Directed bench for unified_memory: a byte-level reference model checked every
// cycle, plus literal expectations for the key load/store/MMIO/timer cases.
module tb_unified_memory;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned BYTES = DEPTH * 4;
  localparam int unsigned HZ    = 2_000_000;
  localparam int unsigned US_CYC = HZ / 1_000_000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, write_data, read_data;
  logic [7:0]  leds;
  logic        access_fault;

  unified_memory #(.INIT_FILE(""), .DEPTH_WORDS(DEPTH), .CLK_HZ(HZ)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .leds         (leds),
    .access_fault (access_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: memory as individual bytes with a known flag each.
  logic [7:0]  mb [BYTES];
  bit          kb [BYTES];
  logic [7:0]  m_leds;
  bit          m_fault;
  int unsigned m_cyc;
  logic [31:0] m_rd;
  bit          m_known;
  bit          m_armed = 0;

  function automatic int unsigned width_of(input bit we, input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return we ? 4 : 0;
    endcase
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return w == 32'hFFFF_FFFC || w == 32'hFFFF_FFF8 || w == 32'hFFFF_FFF4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [31:0] a,
                                         input logic [2:0] f3, input bit we);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * (a % 4)));
    h = 16'(w >> (8 * (a % 4)));
    if (we && f3 inside {3'd3, 3'd6, 3'd7}) return w;
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd4:    return {24'd0, b};
      3'd1:    return 32'($signed(h));
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    int unsigned sz;
    int unsigned base;
    logic [31:0] w;
    bit          f, kn;
    if (reset) begin
      m_rd = 0; m_known = 1; m_leds = 0; m_fault = 0; m_cyc = 0;
    end else begin
      sz = width_of(mem_write, funct3);
      f  = (sz == 0) || !(address < BYTES || is_mmio(address)) || (address % sz != 0);
      w  = 0; kn = 1;
      if (address < BYTES) begin
        base = address & 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) begin
          w  = w | (32'(mb[base + k]) << (8 * k));
          kn = kn && kb[base + k];
        end
      end else if ((address & 32'hFFFF_FFFC) == 32'hFFFF_FFFC) w = {24'd0, m_leds};
      else if ((address & 32'hFFFF_FFFC) == 32'hFFFF_FFF8) w = (m_cyc / US_CYC) / 1000;
      else if ((address & 32'hFFFF_FFFC) == 32'hFFFF_FFF4) w = m_cyc / US_CYC;
      if (f) begin
        m_rd = 0; m_known = 1; m_fault = 1;
      end else begin
        m_rd = extend(w, address, funct3, mem_write); m_known = kn;
        if (mem_write)
          for (int k = 0; k < int'(sz); k++) begin
            if (address + k < BYTES) begin
              mb[address + k] = 8'(write_data >> (8 * k));
              kb[address + k] = 1;
            end else if (address + k == 32'hFFFF_FFFC) m_leds = 8'(write_data >> (8 * k));
          end
      end
      m_cyc++;
    end
    m_armed = 1;
  end

  always @(negedge clk) begin
    if (m_armed) begin
      if (m_known) chk("model_read_data", read_data, m_rd);
      chk("model_leds", {24'd0, leds}, {24'd0, m_leds});
      chk("model_access_fault", {31'd0, access_fault}, {31'd0, m_fault});
    end
  end

  task automatic idle();
    mem_write = 0; funct3 = 3'd2; address = 0; write_data = 0;
  endtask

  task automatic op(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    mem_write = we; funct3 = f3; address = a; write_data = d;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    repeat (n) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    for (int i = 0; i < int'(BYTES); i++) kb[i] = 0;
    idle();
    do_reset(3);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_leds", {24'd0, leds}, 32'd0);
    chk("reset_fault", {31'd0, access_fault}, 32'd0);

    op(1, 3'd2, 32'h0, 32'h0);
    op(1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    op(0, 3'd2, 32'h10, 0); chk("lw_10", read_data, 32'hDEAD_BEEF);
    op(0, 3'd0, 32'h13, 0); chk("lb_13", read_data, 32'hFFFF_FFDE);
    op(0, 3'd4, 32'h13, 0); chk("lbu_13", read_data, 32'h0000_00DE);
    op(0, 3'd1, 32'h12, 0); chk("lh_12", read_data, 32'hFFFF_DEAD);
    op(0, 3'd5, 32'h10, 0); chk("lhu_10", read_data, 32'h0000_BEEF);
    op(1, 3'd0, 32'h11, 32'h0000_0077);
    op(0, 3'd2, 32'h10, 0); chk("sb_11", read_data, 32'hDEAD_77EF);
    op(1, 3'd1, 32'h12, 32'h0000_CAFE);
    op(0, 3'd2, 32'h10, 0); chk("sh_12", read_data, 32'hCAFE_77EF);

    op(1, 3'd2, 32'h30, 32'h1111_1111);
    op(1, 3'd2, 32'h30, 32'h2222_2222); chk("rbw_old", read_data, 32'h1111_1111);
    op(0, 3'd2, 32'h30, 0); chk("rbw_new", read_data, 32'h2222_2222);

    op(1, 3'd2, 32'hFFFF_FFFC, 32'h0000_00A5); chk("leds_a5", {24'd0, leds}, 32'h0000_00A5);
    op(0, 3'd2, 32'hFFFF_FFFC, 0); chk("lw_leds", read_data, 32'h0000_00A5);
    op(1, 3'd2, 32'hFFFF_FFF4, 32'h1234); chk("ro_write_nofault", {31'd0, access_fault}, 32'd0);

    op(1, 3'd1, 32'h11, 32'h1234); chk("sh_mis_fault", {31'd0, access_fault}, 32'd1);
    op(0, 3'd2, 32'h10, 0); chk("sh_mis_unchanged", read_data, 32'hCAFE_77EF);
    op(0, 3'd2, 32'h1000, 0); chk("unmapped_rd", read_data, 32'd0);
    op(0, 3'd3, 32'h10, 0); chk("f3_3_load_rd", read_data, 32'd0);
    op(0, 3'd2, 32'h12, 0); chk("lw_mis_rd", read_data, 32'd0);
    op(1, 3'd7, 32'h40, 32'hABCD_0123);
    op(0, 3'd2, 32'h40, 0); chk("f3_7_store", read_data, 32'hABCD_0123);
    chk("fault_held", {31'd0, access_fault}, 32'd1);

    op(1, 3'd2, 32'h20, 32'h600D_600D);
    mem_write = 1; funct3 = 3'd2; address = 32'h20; write_data = 32'h0000_0BAD;
    do_reset(2);
    idle();
    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_fault", {31'd0, access_fault}, 32'd0);
    op(0, 3'd2, 32'h20, 0); chk("rst_store_suppressed", read_data, 32'h600D_600D);

    do_reset(2);
    repeat (2000) @(posedge clk);
    #1;
    op(0, 3'd2, 32'hFFFF_FFF4, 0); chk("micros_1000", read_data, 32'd1000);
    op(0, 3'd2, 32'hFFFF_FFF8, 0); chk("millis_1", read_data, 32'd1);
    chk("final_fault", {31'd0, access_fault}, 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
